cr_clic_arb: RTL and testbench

Interrupt arbiter of the CLIC: collects the per-interrupt request, level and vectoring outputs of all CLIC kid instances and selects the single highest-level pending interrupt above the core's threshold. It presents that interrupt to the core with a valid/ack handshake. On acceptance it returns a one-cycle one-hot claim to the winning kid so that kid clears its edge pending state. Disabled or dummy kids tie their request low and are never selected.

---
 rtl/cr_clic_pkg.sv | 21 ++
 rtl/cr_clic_arb_cmp.sv | 31 +++
 rtl/cr_clic_arb.sv | 146 ++++++++++++++
 tb/tb_cr_clic_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_clic_pkg.sv
// rtl/cr_clic_pkg.sv - shared CLIC constants, arbiter FSM encoding and ID width helper
`ifndef CLIC_INTCTLBITS
`define CLIC_INTCTLBITS 3
`endif

package cr_clic_pkg;

   localparam int CLIC_LVL_W = `CLIC_INTCTLBITS + 1;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_OFFER = 4'b0010,
      ST_CLAIM = 4'b0100,
      ST_BLANK = 4'b1000
   } arb_state_e;

   function automatic int clic_id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cr_clic_arb_cmp.sv
// rtl/cr_clic_arb_cmp.sv - two-input compare node of the arbitration tree
module cr_clic_arb_cmp
   import cr_clic_pkg::*;
#(
   parameter int ID_W  = 6,
   parameter int LVL_W = CLIC_LVL_W
) (
   input  logic             l_vld,
   input  logic [ID_W-1:0]  l_id,
   input  logic [LVL_W-1:0] l_il,
   input  logic             l_hv,
   input  logic             r_vld,
   input  logic [ID_W-1:0]  r_id,
   input  logic [LVL_W-1:0] r_il,
   input  logic             r_hv,
   output logic             o_vld,
   output logic [ID_W-1:0]  o_id,
   output logic [LVL_W-1:0] o_il,
   output logic             o_hv
);

   logic pick_r;

   // Right side wins only on a strictly higher level; invalid inputs carry zeros.
   assign pick_r = r_vld && (!l_vld || (r_il > l_il));
   assign o_vld  = l_vld | r_vld;
   assign o_id   = pick_r ? r_id : l_id;
   assign o_il   = pick_r ? r_il : l_il;
   assign o_hv   = pick_r ? r_hv : l_hv;

endmodule

// File: rtl/cr_clic_arb.sv
// rtl/cr_clic_arb.sv - CLIC interrupt arbiter: max-level select, core offer/ack, kid claim
module cr_clic_arb
   import cr_clic_pkg::*;
#(
   parameter int INT_NUM    = 64,
   parameter int INTCTLBITS = `CLIC_INTCTLBITS,
   parameter int ID_W       = clic_id_width(INT_NUM)
) (
   input  logic                             clic_clk,
   input  logic                             clic_rst,
   input  logic [INT_NUM-1:0]               kid_arb_int_req,
   input  logic [INT_NUM*(INTCTLBITS+1)-1:0] kid_arb_int_all,
   input  logic [INT_NUM-1:0]               kid_arb_int_hv,
   input  logic [INTCTLBITS:0]              ctrl_arb_int_thresh,
   input  logic                             cpu_arb_int_ack,
   output logic                             arb_cpu_int_vld,
   output logic [ID_W-1:0]                  arb_cpu_int_id,
   output logic [INTCTLBITS:0]              arb_cpu_int_il,
   output logic                             arb_cpu_int_hv,
   output logic [INT_NUM-1:0]               arb_kid_claim
);

   localparam int LVL_W  = INTCTLBITS + 1;
   localparam int LEAVES = 1 << $clog2(INT_NUM);
   localparam int NODES  = 2 * LEAVES - 1;

   // Heap-ordered tree: node k has children 2k+1 (lower indices) and 2k+2.
   for (genvar k = 0; k < NODES; k++) begin : g_node
      logic             vld;
      logic [ID_W-1:0]  id;
      logic [LVL_W-1:0] il;
      logic             hv;

      if (k >= LEAVES - 1) begin : g_leaf
         localparam int I = k - (LEAVES - 1);
         if (I < INT_NUM) begin : g_real
            logic elig;
            assign elig = kid_arb_int_req[I] &&
                          (kid_arb_int_all[I*LVL_W +: LVL_W] > ctrl_arb_int_thresh);
            assign vld = elig;
            assign id  = elig ? ID_W'(I) : '0;
            assign il  = elig ? kid_arb_int_all[I*LVL_W +: LVL_W] : '0;
            assign hv  = elig & kid_arb_int_hv[I];
         end else begin : g_pad
            assign vld = 1'b0;
            assign id  = '0;
            assign il  = '0;
            assign hv  = 1'b0;
         end
      end else begin : g_int
         cr_clic_arb_cmp #(.ID_W(ID_W), .LVL_W(LVL_W)) u_cmp (
            .l_vld (g_node[2*k+1].vld),
            .l_id  (g_node[2*k+1].id),
            .l_il  (g_node[2*k+1].il),
            .l_hv  (g_node[2*k+1].hv),
            .r_vld (g_node[2*k+2].vld),
            .r_id  (g_node[2*k+2].id),
            .r_il  (g_node[2*k+2].il),
            .r_hv  (g_node[2*k+2].hv),
            .o_vld (vld),
            .o_id  (id),
            .o_il  (il),
            .o_hv  (hv)
         );
      end
   end

   logic             cand_vld;
   logic [ID_W-1:0]  cand_id;
   logic [LVL_W-1:0] cand_il;
   logic             cand_hv;

   always_ff @(posedge clic_clk) begin
      if (clic_rst) begin
         cand_vld <= 1'b0;
         cand_id  <= '0;
         cand_il  <= '0;
         cand_hv  <= 1'b0;
      end else begin
         cand_vld <= g_node[0].vld;
         cand_id  <= g_node[0].id;
         cand_il  <= g_node[0].il;
         cand_hv  <= g_node[0].hv;
      end
   end

   arb_state_e       state_q, state_d;
   logic             load_out, latch_claim;
   logic [ID_W-1:0]  out_id_q, claim_id_q;
   logic [LVL_W-1:0] out_il_q;
   logic             out_hv_q;

   always_comb begin
      state_d     = state_q;
      load_out    = 1'b0;
      latch_claim = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cand_vld) begin
               load_out = 1'b1;
               state_d  = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (cpu_arb_int_ack) begin
               latch_claim = 1'b1;
               state_d     = ST_CLAIM;
            end else if (!cand_vld) begin
               state_d = ST_IDLE;
            end else begin
               load_out = 1'b1;
            end
         end
         ST_CLAIM: state_d = ST_BLANK;
         ST_BLANK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clic_clk) begin
      if (clic_rst) begin
         state_q    <= ST_IDLE;
         out_id_q   <= '0;
         out_il_q   <= '0;
         out_hv_q   <= 1'b0;
         claim_id_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_out) begin
            out_id_q <= cand_id;
            out_il_q <= cand_il;
            out_hv_q <= cand_hv;
         end
         if (latch_claim) claim_id_q <= out_id_q;
      end
   end

   // Gating with reset keeps a claim from leaking out while reset is being applied.
   assign arb_cpu_int_vld = (state_q == ST_OFFER) && !clic_rst;
   assign arb_cpu_int_id  = out_id_q;
   assign arb_cpu_int_il  = out_il_q;
   assign arb_cpu_int_hv  = out_hv_q;
   assign arb_kid_claim   = ((state_q == ST_CLAIM) && !clic_rst) ?
                            (INT_NUM'(1) << claim_id_q) : '0;

endmodule

// File: tb/tb_cr_clic_arb.sv
// tb/tb_cr_clic_arb.sv - scoreboard bench for cr_clic_arb
module tb_cr_clic_arb;

   localparam int N  = 64;
   localparam int LW = 4;
   localparam int IW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, hv, claim;
   logic [N*LW-1:0] lvl;
   logic [LW-1:0]   thresh;
   logic            ack;
   logic            vld, ohv;
   logic [IW-1:0]   id;
   logic [LW-1:0]   il;

   int errors = 0;
   int checks = 0;
   logic [11:0]  exp_q[$];
   logic [N-1:0] claim_q[$];
   logic [11:0]  e;
   logic [N-1:0] ec;
   logic         mon_en = 1'b0;
   logic [N-1:0] claim_seen;

   always #5 clk = ~clk;

   cr_clic_arb #(.INT_NUM(N), .INTCTLBITS(3)) dut (
      .clic_clk            (clk),
      .clic_rst            (rst),
      .kid_arb_int_req     (req),
      .kid_arb_int_all     (lvl),
      .kid_arb_int_hv      (hv),
      .ctrl_arb_int_thresh (thresh),
      .cpu_arb_int_ack     (ack),
      .arb_cpu_int_vld     (vld),
      .arb_cpu_int_id      (id),
      .arb_cpu_int_il      (il),
      .arb_cpu_int_hv      (ohv),
      .arb_kid_claim       (claim)
   );

   always @(negedge clk) begin
      if (mon_en) claim_seen <= claim_seen | claim;
      else        claim_seen <= '0;
   end

   function automatic logic [11:0] obs();
      return vld ? {1'b1, id, il, ohv} : 12'h000;
   endfunction

   function automatic logic [11:0] model();
      logic          found;
      int            best_i;
      logic [LW-1:0] best, l;
      found = 1'b0; best_i = 0; best = '0;
      for (int i = 0; i < N; i++) begin
         l = lvl[i*LW +: LW];
         if (req[i] && (l > thresh) && (!found || (l > best))) begin
            found = 1'b1; best = l; best_i = i;
         end
      end
      return found ? {1'b1, IW'(best_i), best, hv[best_i]} : 12'h000;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      req = '0; lvl = '0; hv = '0;
   endtask

   task automatic set_kid(input int i, input int l, input logic h);
      req[i] = 1'b1;
      lvl[i*LW +: LW] = LW'(l);
      hv[i] = h;
   endtask

   task automatic test_reset();
      rst = 1'b1; ack = 1'b0; thresh = '0; clear_all();
      tick(); tick();
      checks++;
      if ({vld, id, il, ohv} !== 12'h000) begin
         errors++; $display("FAIL reset_outputs: got %h want 000", {vld, id, il, ohv});
      end
      checks++;
      if (claim !== '0) begin
         errors++; $display("FAIL reset_claim: got %h want 0", claim);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      clear_all(); thresh = '0;
      set_kid(5, 6, 1'b1);
      exp_q.push_back(model());
      tick();
      checks++;
      if (obs() !== 12'h000) begin
         errors++; $display("FAIL single_early: got %h want 000", obs());
      end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL single_offer: got %h want %h", obs(), e);
      end
      ack = 1'b1;
      claim_q.push_back(onehot(5));
      tick();
      ack = 1'b0;
      ec = claim_q.pop_front(); checks++;
      if (claim !== ec || vld !== 1'b0) begin
         errors++; $display("FAIL single_claim: got claim=%h vld=%b want claim=%h vld=0", claim, vld, ec);
      end
      req[5] = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         tick();
         checks++;
         if (claim !== '0 || vld !== 1'b0) begin
            errors++; $display("FAIL single_after_m%0d: got claim=%h vld=%b want 0/0", c, claim, vld);
         end
      end
   endtask

   task automatic test_tie();
      clear_all();
      set_kid(3, 7, 1'b0); set_kid(9, 7, 1'b0); set_kid(12, 5, 1'b0);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL tie_low_index: got %h want %h", obs(), e);
      end
      req[3] = 1'b0;
      exp_q.push_back(model());
      tick();
      checks++;
      if (obs() !== {1'b1, 6'd3, 4'd7, 1'b0}) begin
         errors++; $display("FAIL tie_lag: got %h want %h", obs(), {1'b1, 6'd3, 4'd7, 1'b0});
      end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL tie_drop: got %h want %h", obs(), e);
      end
      clear_all();
      tick(); tick();
      checks++;
      if (obs() !== 12'h000) begin
         errors++; $display("FAIL tie_withdraw: got %h want 000", obs());
      end
   endtask

   task automatic test_threshold();
      clear_all(); thresh = 4'd4;
      set_kid(2, 4, 1'b0);
      exp_q.push_back(model());
      tick(); tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL thresh_equal: got %h want %h", obs(), e);
      end
      thresh = 4'd3;
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL thresh_below: got %h want %h", obs(), e);
      end
      thresh = 4'd4;
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL thresh_raise: got %h want %h", obs(), e);
      end
      clear_all(); thresh = '0;
      tick();
   endtask

   task automatic test_preempt();
      clear_all();
      set_kid(1, 2, 1'b0);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL preempt_first: got %h want %h", obs(), e);
      end
      set_kid(40, 15, 1'b1);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL preempt_high: got %h want %h", obs(), e);
      end
      ack = 1'b1;
      claim_q.push_back(onehot(40));
      tick();
      ack = 1'b0;
      ec = claim_q.pop_front(); checks++;
      if (claim !== ec) begin
         errors++; $display("FAIL preempt_claim: got %h want %h", claim, ec);
      end
      req[40] = 1'b0;
      exp_q.push_back(model());
      tick(); tick();
      checks++;
      if (vld !== 1'b0) begin
         errors++; $display("FAIL preempt_blank: got vld=%b want 0", vld);
      end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL preempt_next: got %h want %h", obs(), e);
      end
      clear_all();
      tick(); tick(); tick();
   endtask

   task automatic test_spurious();
      clear_all();
      tick(); tick();
      ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (claim !== '0 || vld !== 1'b0) begin
            errors++; $display("FAIL spurious_ack%0d: got claim=%h vld=%b want 0/0", c, claim, vld);
         end
      end
      ack = 1'b0;
      set_kid(7, 3, 1'b0);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL spurious_still_idle: got %h want %h", obs(), e);
      end
      clear_all();
      tick(); tick();
   endtask

   task automatic test_ack_edge();
      clear_all();
      set_kid(10, 3, 1'b0);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL edge_offer: got %h want %h", obs(), e);
      end
      set_kid(20, 9, 1'b0);
      tick();
      checks++;
      if (obs() !== {1'b1, 6'd10, 4'd3, 1'b0}) begin
         errors++; $display("FAIL edge_shown: got %h want %h", obs(), {1'b1, 6'd10, 4'd3, 1'b0});
      end
      ack = 1'b1;
      claim_q.push_back(onehot(10));
      tick();
      ack = 1'b0;
      ec = claim_q.pop_front(); checks++;
      if (claim !== ec) begin
         errors++; $display("FAIL edge_claim: got %h want %h", claim, ec);
      end
      req[10] = 1'b0;
      exp_q.push_back(model());
      tick(); tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL edge_next: got %h want %h", obs(), e);
      end
      clear_all();
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      clear_all();
      set_kid(0, 1, 1'b0);
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL rstmid_offer: got %h want %h", obs(), e);
      end
      mon_en = 1'b1;
      rst = 1'b1; ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if ({vld, id, il, ohv} !== 12'h000 || claim !== '0) begin
         errors++; $display("FAIL rstmid_offer_clear: got %h claim=%h want 000/0", {vld, id, il, ohv}, claim);
      end
      rst = 1'b0;
      exp_q.push_back(model());
      tick();
      checks++;
      if (vld !== 1'b0) begin
         errors++; $display("FAIL rstmid_plus1: got vld=%b want 0", vld);
      end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL rstmid_plus2: got %h want %h", obs(), e);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0; rst = 1'b1;
      #1;
      checks++;
      if (claim !== '0) begin
         errors++; $display("FAIL rstclaim_pulse: got %h want 0", claim);
      end
      tick();
      rst = 1'b0;
      checks++;
      if ({vld, id, il, ohv} !== 12'h000 || claim !== '0) begin
         errors++; $display("FAIL rstclaim_clear: got %h claim=%h want 000/0", {vld, id, il, ohv}, claim);
      end
      exp_q.push_back(model());
      tick(); tick();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL rstclaim_reoffer: got %h want %h", obs(), e);
      end
      checks++;
      if (claim_seen !== '0) begin
         errors++; $display("FAIL rst_no_claim: got %h want 0", claim_seen);
      end
      mon_en = 1'b0;
      clear_all();
      tick(); tick(); tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ack = 1'b0; thresh = '0;
      req = '0; lvl = '0; hv = '0;
      test_reset();
      test_single();
      test_tie();
      test_threshold();
      test_preempt();
      test_spurious();
      test_ack_edge();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
